// File: rtl/mem_port_arbiter.sv
// Shares one registered memory port between IF fetches and MEM loads/stores.
// Latency: request seen at t -> mem_req at t+1; mem_ready at k -> ready pulse at k+1, idle at k+2.
// Backpressure: requesters hold their request and see i_stall/d_stall until their ready pulse.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic                i_kill,
    output logic                i_ready,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_stall,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_ready,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_stall,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_ready,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                err
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;

    state_t        state;
    logic [SW-1:0] starve_cnt;
    logic          kill_flag;
    logic          fetch_ok;
    logic          starved;
    logic          grant_i;
    logic          grant_d;

    assign fetch_ok = i_req & ~i_kill;
    assign starved  = (starve_cnt == SW'(STARVE_MAX));
    assign grant_i  = fetch_ok & (~d_req | starved);
    assign grant_d  = d_req & ~grant_i;

    assign i_stall = i_req & ~i_ready;
    assign d_stall = d_req & ~d_ready;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= IDLE;
            starve_cnt <= '0;
            kill_flag  <= 1'b0;
            i_ready    <= 1'b0;
            d_ready    <= 1'b0;
            i_rdata    <= '0;
            d_rdata    <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_be     <= '0;
            err        <= 1'b0;
        end else begin
            i_ready <= 1'b0;
            d_ready <= 1'b0;
            if (mem_ready && (state == IDLE || state == DONE))
                err <= 1'b1;

            unique case (state)
                IDLE: begin
                    // A data grant with a live fetch implies starved is low, so this saturates.
                    if (!i_req || grant_i)
                        starve_cnt <= '0;
                    else if (grant_d && fetch_ok)
                        starve_cnt <= starve_cnt + SW'(1);

                    if (grant_i) begin
                        state    <= BUSY_I;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= i_addr;
                        mem_be   <= '1;
                    end else if (grant_d) begin
                        state     <= BUSY_D;
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        mem_be    <= d_be;
                    end
                end
                BUSY_I: begin
                    if (mem_ready) begin
                        state     <= DONE;
                        mem_req   <= 1'b0;
                        kill_flag <= 1'b0;
                        if (!(kill_flag || i_kill)) begin
                            i_ready <= 1'b1;
                            i_rdata <= mem_rdata;
                        end
                    end else if (i_kill) begin
                        kill_flag <= 1'b1;
                    end
                end
                BUSY_D: begin
                    if (mem_ready) begin
                        state   <= DONE;
                        mem_req <= 1'b0;
                        d_ready <= 1'b1;
                        if (!mem_we)
                            d_rdata <= mem_rdata;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int SMAX = 4;

    logic        CLK = 1'b0, RESET = 1'b1;
    logic        i_req = 1'b0, i_kill = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ready = 1'b0;
    logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
    logic [3:0]  d_be = '0;
    logic        i_ready, i_stall, d_ready, d_stall, mem_req, mem_we, err;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SMAX)) dut (
        .CLK(CLK), .RESET(RESET),
        .i_req(i_req), .i_addr(i_addr), .i_kill(i_kill), .i_ready(i_ready), .i_rdata(i_rdata), .i_stall(i_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_ready(d_ready), .d_rdata(d_rdata), .d_stall(d_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .err(err)
    );

    initial forever #5 CLK = ~CLK;

    int n_cmp = 0, n_bad = 0;
    bit chk_en = 0;

    task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic timeout(string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: expected event never happened (t=%0t)", nm, $time);
    endtask

    // Reference model: one outstanding transaction, ready one cycle after completion,
    // one dead cycle afterwards, data-first arbitration with an IF starvation limit.
    logic        exp_i_ready = 0, exp_d_ready = 0, exp_mem_req = 0, exp_mem_we = 0, exp_err = 0;
    logic [31:0] exp_i_rdata = 0, exp_d_rdata = 0, exp_mem_addr = 0, exp_mem_wdata = 0;
    logic [3:0]  exp_mem_be = 0;
    bit          m_busy = 0, m_done = 0, m_owner_d = 0, m_killed = 0;
    int          m_starve = 0, m_wait = 0, m_lat = 0, fixed_lat = 0;
    bit          stray_mr = 0;
    bit          glog[$];
    logic [31:0] gaddr[$];
    logic [31:0] mem_arr [int];

    function automatic logic [31:0] mem_rd(logic [31:0] a);
        int w = int'(a >> 2);
        return mem_arr.exists(w) ? mem_arr[w] : (a ^ 32'h5A5A_0000);
    endfunction

    task automatic mem_wr(logic [31:0] a, logic [31:0] wd, logic [3:0] be);
        logic [31:0] word = mem_rd(a);
        for (int b = 0; b < 4; b++)
            if (be[b]) word[8*b +: 8] = wd[8*b +: 8];
        mem_arr[int'(a >> 2)] = word;
    endtask

    task automatic model_step();
        bit fetch_ok, gi, gd;
        exp_i_ready = 0;
        exp_d_ready = 0;
        if (RESET) begin
            {exp_mem_req, exp_mem_we, exp_err} = '0;
            {exp_i_rdata, exp_d_rdata, exp_mem_addr, exp_mem_wdata} = '0;
            exp_mem_be = '0;
            {m_busy, m_done, m_killed} = '0;
            m_starve = 0;
            return;
        end
        if (mem_ready && !m_busy) exp_err = 1;
        if (m_done) begin
            m_done = 0;
        end else if (m_busy) begin
            if (!m_owner_d && i_kill) m_killed = 1;
            if (mem_ready) begin
                m_busy = 0;
                m_done = 1;
                exp_mem_req = 0;
                if (m_owner_d) begin
                    exp_d_ready = 1;
                    if (!exp_mem_we) exp_d_rdata = mem_rdata;
                end else if (!m_killed) begin
                    exp_i_ready = 1;
                    exp_i_rdata = mem_rdata;
                end
                m_killed = 0;
            end
        end else begin
            fetch_ok = i_req && !i_kill;
            gi = fetch_ok && (!d_req || m_starve == SMAX);
            gd = d_req && !gi;
            if (!i_req || gi) m_starve = 0;
            else if (gd && fetch_ok) m_starve = (m_starve < SMAX) ? m_starve + 1 : SMAX;
            if (gi || gd) begin
                m_busy = 1;
                m_owner_d = gd;
                m_wait = 0;
                m_lat = (fixed_lat >= 0) ? fixed_lat : $urandom_range(0, 3);
                exp_mem_req = 1;
                glog.push_back(gd);
                gaddr.push_back(gd ? d_addr : i_addr);
            end
            if (gi) begin
                exp_mem_we = 0; exp_mem_addr = i_addr; exp_mem_be = 4'hF;
            end else if (gd) begin
                exp_mem_we = d_we; exp_mem_addr = d_addr; exp_mem_wdata = d_wdata; exp_mem_be = d_be;
            end
        end
    endtask

    task automatic mem_drive();
        if (m_busy) begin
            if (m_wait == m_lat) begin
                mem_ready = 1;
                if (exp_mem_we) begin
                    mem_rdata = $urandom;
                    mem_wr(exp_mem_addr, exp_mem_wdata, exp_mem_be);
                end else begin
                    mem_rdata = mem_rd(exp_mem_addr);
                end
            end else begin
                mem_ready = 0;
                mem_rdata = $urandom;
            end
            m_wait++;
        end else begin
            mem_ready = stray_mr;
            mem_rdata = $urandom;
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step();
        #1;
        mem_drive();
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            cmp("i_ready",   i_ready,   exp_i_ready);
            cmp("i_rdata",   i_rdata,   exp_i_rdata);
            cmp("i_stall",   i_stall,   i_req & ~exp_i_ready);
            cmp("d_ready",   d_ready,   exp_d_ready);
            cmp("d_rdata",   d_rdata,   exp_d_rdata);
            cmp("d_stall",   d_stall,   d_req & ~exp_d_ready);
            cmp("mem_req",   mem_req,   exp_mem_req);
            cmp("mem_we",    mem_we,    exp_mem_we);
            cmp("mem_addr",  mem_addr,  exp_mem_addr);
            cmp("mem_wdata", mem_wdata, exp_mem_wdata);
            cmp("mem_be",    mem_be,    exp_mem_be);
            cmp("err",       err,       exp_err);
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_i(string nm);
        for (int k = 0; k < 40; k++) begin
            tick();
            if (exp_i_ready) return;
        end
        timeout(nm);
    endtask

    task automatic wait_d(string nm);
        for (int k = 0; k < 40; k++) begin
            tick();
            if (exp_d_ready) return;
        end
        timeout(nm);
    endtask

    initial begin
        int n_mq, n_dr, n_ir, n_irm, nd, pat, smax_dut, s_after;
        bit d_hold, i_hold, got_i, done, if_end, d_end;

        // Reset
        tick();
        chk_en = 1;
        cmp("rst_mem_req", mem_req, 0);
        cmp("rst_i_ready", i_ready, 0);
        cmp("rst_err", err, 0);
        cmp("rst_mem_addr", mem_addr, 0);
        RESET = 0;

        // Single fetch, memory answers on the second cycle of mem_req
        mem_arr[32'h40 >> 2] = 32'h2008_0005;
        fixed_lat = 1;
        i_req = 1; i_addr = 32'h40;
        n_mq = 0; n_dr = 0; done = 0;
        for (int k = 0; k < 20 && !done; k++) begin
            tick();
            if (mem_req) n_mq++;
            if (d_ready) n_dr++;
            if (exp_i_ready) done = 1;
        end
        if (!done) timeout("fetch_done");
        cmp("fetch_rdata", i_rdata, 32'h2008_0005);
        cmp("fetch_model_rdata", exp_i_rdata, 32'h2008_0005);
        cmp("fetch_ready", i_ready, 1);
        cmp("fetch_stall_low", i_stall, 0);
        cmp("fetch_memreq_cycles", n_mq, 2);
        cmp("fetch_no_dready", n_dr, 0);
        tick();
        i_req = 0;

        // Simultaneous fetch and load: data first, fetch right after DONE
        mem_arr[32'h100 >> 2] = 32'hDEAD_BEEF;
        mem_arr[32'h44 >> 2]  = 32'h8D09_0004;
        fixed_lat = 0;
        glog.delete(); gaddr.delete();
        i_req = 1; i_addr = 32'h44;
        d_req = 1; d_we = 0; d_addr = 32'h100; d_be = 4'hF;
        wait_d("sim_load_done");
        cmp("sim_load_rdata", d_rdata, 32'hDEAD_BEEF);
        cmp("sim_first_is_data", glog.size() == 1 && glog[0], 1);
        tick();
        d_req = 0;
        tick();
        cmp("sim_fetch_granted", glog.size(), 2);
        cmp("sim_fetch_addr", gaddr[gaddr.size()-1], 32'h44);
        wait_i("sim_fetch_done");
        cmp("sim_fetch_rdata", i_rdata, 32'h8D09_0004);
        tick();
        i_req = 0;
        repeat (4) tick();
        cmp("sim_no_reissue", glog.size(), 2);

        // Store with partial byte enables
        mem_arr[32'h200 >> 2] = 32'hAABB_CCDD;
        fixed_lat = 3;
        d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'h1122_3344; d_be = 4'b0011;
        wait_d("store_done");
        cmp("store_d_rdata_kept", d_rdata, 32'hDEAD_BEEF);
        cmp("store_mem_we", mem_we, 1);
        cmp("store_mem_be", mem_be, 4'b0011);
        cmp("store_mem_wdata", mem_wdata, 32'h1122_3344);
        cmp("store_mem_word", mem_rd(32'h200), 32'hAABB_3344);
        tick();
        d_req = 0; d_we = 0;

        // Kill mid-wait, then a normal fetch
        mem_arr[32'h80 >> 2] = 32'h8C00_0080;
        i_req = 1; i_addr = 32'h48;
        tick();
        tick();
        i_kill = 1;
        tick();
        i_kill = 0; i_req = 0;
        n_ir = 0; n_irm = 0;
        repeat (8) begin
            tick();
            if (i_ready) n_ir++;
            if (exp_i_ready) n_irm++;
        end
        cmp("kill_no_ready", n_ir, 0);
        cmp("kill_model_no_ready", n_irm, 0);
        cmp("kill_rdata_kept", i_rdata, 32'h8D09_0004);
        i_req = 1; i_addr = 32'h80;
        wait_i("after_kill_fetch");
        cmp("after_kill_rdata", i_rdata, 32'h8C00_0080);
        tick();
        i_req = 0;
        tick();

        // Starvation: IF held while data keeps coming back-to-back
        fixed_lat = 0;
        glog.delete(); gaddr.delete();
        i_req = 1; i_addr = 32'h60;
        d_req = 1; d_we = 0; d_addr = 32'h300; d_be = 4'hF;
        nd = 0; d_hold = 0; i_hold = 0; got_i = 0; smax_dut = 0; s_after = -1; done = 0;
        for (int k = 0; k < 200 && !done; k++) begin
            tick();
            if (int'(dut.starve_cnt) > smax_dut) smax_dut = int'(dut.starve_cnt);
            if (glog.size() == 5 && !got_i) begin got_i = 1; s_after = int'(dut.starve_cnt); end
            if (d_hold) begin
                d_hold = 0;
                if (nd < 5) begin
                    d_we = 1'($urandom); d_addr = 32'($urandom_range(0, 63)) << 2;
                    d_wdata = $urandom; d_be = 4'($urandom);
                end else d_req = 0;
            end
            if (exp_d_ready) begin nd++; d_hold = 1; end
            if (i_hold) begin i_hold = 0; i_req = 0; end
            if (exp_i_ready) i_hold = 1;
            if (nd == 5 && !d_req && !i_req) done = 1;
        end
        if (!done) timeout("starve_done");
        pat = 0;
        foreach (glog[j]) pat = pat * 2 + int'(glog[j]);
        cmp("starve_count", glog.size(), 6);
        cmp("starve_order", pat, 32'b111101);
        cmp("starve_peak", smax_dut, SMAX);
        cmp("starve_cleared", s_after, 0);
        tick();

        // Reset mid data transaction, then a stray completion
        fixed_lat = 6;
        d_req = 1; d_we = 0; d_addr = 32'h100; d_be = 4'hF;
        tick();
        tick();
        RESET = 1; d_req = 0;
        tick();
        cmp("midrst_mem_req", mem_req, 0);
        cmp("midrst_d_rdata", d_rdata, 0);
        cmp("midrst_i_rdata", i_rdata, 0);
        cmp("midrst_mem_be", mem_be, 0);
        cmp("midrst_state", dut.state, 0);
        RESET = 0;
        tick();
        stray_mr = 1;
        tick();
        stray_mr = 0;
        tick();
        cmp("stray_err", err, 1);
        repeat (5) tick();
        cmp("stray_err_sticky", err, 1);
        RESET = 1;
        tick();
        cmp("err_cleared", err, 0);
        RESET = 0;

        // Randomized traffic
        fixed_lat = -1;
        glog.delete(); gaddr.delete();
        if_end = 0; d_end = 0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            i_kill = 0;
            if (if_end) begin
                if_end = 0; i_req = 0;
            end else if (i_req && exp_i_ready) begin
                if_end = 1;
            end else if (i_req && $urandom_range(0, 19) == 0) begin
                i_kill = 1; if_end = 1;
            end else if (!i_req && $urandom_range(0, 2) == 0) begin
                i_req = 1; i_addr = 32'($urandom_range(0, 255)) << 2;
            end
            if (d_end) begin
                d_end = 0;
                if ($urandom_range(0, 1) == 1) begin
                    d_we = 1'($urandom); d_addr = 32'($urandom_range(0, 63)) << 2;
                    d_wdata = $urandom; d_be = 4'($urandom);
                end else d_req = 0;
            end else if (d_req && exp_d_ready) begin
                d_end = 1;
            end else if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req = 1; d_we = 1'($urandom); d_addr = 32'($urandom_range(0, 63)) << 2;
                d_wdata = $urandom; d_be = 4'($urandom);
            end
        end
        cmp("rand_traffic", glog.size() > 200, 1);
        i_req = 0; d_req = 0; i_kill = 0;
        repeat (10) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
